acc_c_credit_buffer: RTL

Credit-based flow-control stage on the compressed accelerator channel (acc_c_req_t / acc_c_rsp_t) between a core complex's outbound acc_c port and the next-level accelerator interconnect. It caps the number of in-flight offloaded instructions at Depth. It stores every returning result in a local FIFO, so a core that holds p_ready low never back-pressures the shared accelerator fabric. Request path is zero-latency and credit-gated; response path is registered.

---
 rtl/acc_pkg.sv | 37 +++
 rtl/acc_rsp_fifo.sv | 68 ++++++
 rtl/acc_c_credit_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types for the compressed accelerator channel.
// The request/response payloads are reused as-is by the credit buffer.
package acc_pkg;

  localparam int unsigned DataWidth             = 32;
  localparam int unsigned NumRs                 = 3;
  localparam int unsigned HartIdWidth           = 8;
  localparam int unsigned AccCreditDepthDefault = 4;

  typedef struct packed {
    logic [31:0]                       instr_data;
    logic [NumRs-1:0][DataWidth-1:0]   rs;
    logic [NumRs-1:0]                  rs_valid;
    logic [HartIdWidth-1:0]            hart_id;
  } acc_c_req_chan_t;

  typedef struct packed {
    logic [4:0]             rd;
    logic [DataWidth-1:0]   data;
    logic                   error;
    logic                   dualwb;
    logic [HartIdWidth-1:0] hart_id;
  } acc_c_rsp_chan_t;

  typedef struct packed {
    logic            q_valid;
    acc_c_req_chan_t q;
    logic            p_ready;
  } acc_c_req_t;

  typedef struct packed {
    logic            q_ready;
    logic            p_valid;
    acc_c_rsp_chan_t p;
  } acc_c_rsp_t;

endpackage

// File: rtl/acc_rsp_fifo.sv
// Response FIFO with flop storage: an entry pushed in one cycle is visible at
// dout the next cycle, never in the same cycle.
module acc_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter type data_t = logic,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  data_t           din,
  input  logic            pop,
  output data_t           dout,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  // Sized to the pointer range so every pointer value indexes a real entry.
  data_t mem [2**PtrW];

  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic            do_push;
  logic            do_pop;

  // Wrap explicitly at Depth-1 so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_reg == CntW'(Depth));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/acc_c_credit_buffer.sv
// Credit-gated offload stage: caps in-flight offloads at Depth and buffers
// every returning result locally so the core never stalls the fabric.
module acc_c_credit_buffer
  import acc_pkg::*;
#(
  parameter int unsigned Depth = AccCreditDepthDefault,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  acc_c_req_t      slv_req_i,
  output acc_c_rsp_t      slv_rsp_o,
  output acc_c_req_t      mst_req_o,
  input  acc_c_rsp_t      mst_rsp_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            idle_o,
  output logic            err_o
);

  logic [CntW-1:0] outstanding_reg;
  logic [CntW-1:0] outstanding_next;
  logic            err_reg;
  logic            err_next;
  logic            credit_ok;
  logic            issue;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  acc_c_rsp_chan_t fifo_head;

  // Only registered state feeds the credit check, keeping the request path
  // free of any dependency on the response handshake.
  assign credit_ok = (outstanding_reg < CntW'(Depth));
  assign issue     = slv_req_i.q_valid & credit_ok & mst_rsp_i.q_ready;
  assign pop       = ~fifo_empty & slv_req_i.p_ready;
  assign push      = mst_rsp_i.p_valid & ~fifo_full;

  always_comb begin
    mst_req_o         = slv_req_i;
    mst_req_o.q_valid = slv_req_i.q_valid & credit_ok;
    mst_req_o.p_ready = ~fifo_full;
  end

  always_comb begin
    slv_rsp_o         = '0;
    slv_rsp_o.q_ready = mst_rsp_i.q_ready & credit_ok;
    slv_rsp_o.p_valid = ~fifo_empty;
    slv_rsp_o.p       = fifo_head;
  end

  acc_rsp_fifo #(
    .Depth  (Depth),
    .data_t (acc_c_rsp_chan_t)
  ) i_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .din   (mst_rsp_i.p),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    outstanding_next = outstanding_reg;
    if (issue && !pop) begin
      outstanding_next = outstanding_reg + CntW'(1);
    end else if (pop && !issue && (outstanding_reg != '0)) begin
      outstanding_next = outstanding_reg - CntW'(1);
    end
  end

  // A response is unexpected once every issued offload already has its
  // result buffered; a full FIFO is the extreme case of that.
  assign err_next = err_reg |
                    (mst_rsp_i.p_valid & (fifo_full | (outstanding_reg == fifo_count)));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign outstanding_o = outstanding_reg;
  assign idle_o        = (outstanding_reg == '0);
  assign err_o         = err_reg;

endmodule
